// File: rtl/multi_seg7_bcd_if.sv
// Display-request bus for multi_seg7_bcd.
// A producer drives start/num. The display driver returns busy/done/overflow
// and the concatenated active-low HEX segments.
interface multi_seg7_bcd_if #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      num;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [7*DIGITS-1:0]   HEX;

  modport master (output start, output num,
                  input  busy, input done, input overflow, input HEX);
  modport slave  (input  start, input num,
                  output busy, output done, output overflow, output HEX);
endinterface

// File: rtl/multi_seg7_bcd.sv
// multi_seg7_bcd: sequential binary-to-BCD display driver (double dabble,
// one bit per clock) for a bank of DIGITS active-low seven-segment displays.
// Leading zeros are blanked and the overflow flag is registered.
// The optional macro MULTI_SEG7_OVERFLOW_DASH_EN shows a dash on every digit
// while overflow is set. Without the macro, the display shows num mod 10^DIGITS.
module multi_seg7_bcd #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  multi_seg7_bcd_if.slave bus
);

  localparam int          CW      = $clog2(WIDTH + 1);
  localparam int          BW      = 4 * DIGITS;
  localparam int unsigned MAX_VAL = 10**DIGITS - 1;
  localparam logic [6:0]  BLANK   = 7'b1111111;
  localparam logic [6:0]  DASH    = 7'b0111111;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_UPDATE} state_t;

  state_t                state;
  logic [WIDTH-1:0]      shreg;
  logic [BW-1:0]         bcd;
  logic [CW-1:0]         cnt;
  logic                  ovf_pending;
  logic                  busy_r;
  logic                  done_r;
  logic                  ovf_r;
  logic [7*DIGITS-1:0]   hex_r;

  logic [BW-1:0]         bcd_adj;
  logic [BW+WIDTH-1:0]   shifted;
  logic [7*DIGITS-1:0]   hex_next;

  // Segment pattern (g..a) for one BCD nibble; codes 10..15 blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return ~7'b0111111;
      4'd1:    return ~7'b0000110;
      4'd2:    return ~7'b1011011;
      4'd3:    return ~7'b1001111;
      4'd4:    return ~7'b1100110;
      4'd5:    return ~7'b1101101;
      4'd6:    return ~7'b1111101;
      4'd7:    return ~7'b0000111;
      4'd8:    return ~7'b1111111;
      4'd9:    return ~7'b1101111;
      default: return BLANK;
    endcase
  endfunction

  // Add-3 correction on every nibble >= 5, then one-bit left shift of {bcd, shreg}.
  // The carry out of the top nibble falls off, so bcd holds num mod 10^DIGITS.
  always_comb begin
    // NOTE: each variable assigned in a combinational block gets a default first,
    // so no path can leave it unassigned and infer a latch.
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, shreg} << 1;
  end

  // Segment decode with leading-zero blanking, scanning from the top digit down.
  always_comb begin
    logic lz;
    hex_next = {DIGITS{BLANK}};
    lz       = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz = lz && (bcd[4*i +: 4] == 4'd0) && (i != 0);
      hex_next[7*i +: 7] = lz ? BLANK : seg7(bcd[4*i +: 4]);
    end
`ifdef MULTI_SEG7_OVERFLOW_DASH_EN
    if (ovf_pending)
      hex_next = {DIGITS{DASH}};
`endif
  end

  // Control FSM: capture on start, shift WIDTH times, then publish the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      shreg       <= '0;
      bcd         <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ovf_r       <= 1'b0;
      hex_r       <= {DIGITS{BLANK}};
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register
      // here samples pre-edge values regardless of statement order.
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            shreg       <= bus.num;
            bcd         <= '0;
            cnt         <= CW'(WIDTH);
            ovf_pending <= (32'(bus.num) > MAX_VAL);
            busy_r      <= 1'b1;
            state       <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd   <= shifted[BW+WIDTH-1 -: BW];
          shreg <= shifted[WIDTH-1:0];
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= S_UPDATE;
        end
        S_UPDATE: begin
          hex_r  <= hex_next;
          ovf_r  <= ovf_pending;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.overflow = ovf_r;
  assign bus.HEX      = hex_r;

endmodule

// File: tb/tb_multi_seg7_bcd.sv
// Directed bench for multi_seg7_bcd: a 10-bit/3-digit instance and a
// 7-bit/2-digit instance. Expected displays come from an arithmetic
// reference model and are queued when each start is driven.
module tb_multi_seg7_bcd;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  multi_seg7_bcd_if #(.WIDTH(10), .DIGITS(3)) a_if ();
  multi_seg7_bcd_if #(.WIDTH(7),  .DIGITS(2)) b_if ();

  multi_seg7_bcd #(.WIDTH(10), .DIGITS(3)) dut_a (.clk(clk), .reset_n(reset_n), .bus(a_if.slave));
  multi_seg7_bcd #(.WIDTH(7),  .DIGITS(2)) dut_b (.clk(clk), .reset_n(reset_n), .bus(b_if.slave));

  typedef struct {
    logic [41:0] hex;
    logic        ovf;
  } exp_t;

  exp_t        sb_a[$];
  exp_t        sb_b[$];
  logic [20:0] prev_a;
  logic [13:0] prev_b;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic exp_t model(input int unsigned v, input int digits);
    exp_t        e;
    int unsigned lim, m, p;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    e.ovf = (v >= lim);
    m     = v % lim;
    e.hex = '0;
    p     = 1;
    for (int i = 0; i < digits; i++) begin
      if (i > 0 && m < p) e.hex[7*i +: 7] = 7'b1111111;
      else                e.hex[7*i +: 7] = seg_ref(int'((m / p) % 10));
      p = p * 10;
    end
`ifdef MULTI_SEG7_OVERFLOW_DASH_EN
    if (e.ovf)
      for (int i = 0; i < digits; i++) e.hex[7*i +: 7] = 7'b0111111;
`endif
    return e;
  endfunction

  // Wait (bounded) for done on instance A, counting negedges.
  task automatic wait_done_a(output int cyc);
    cyc = 0;
    while (a_if.done !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic result_a(input string tag);
    exp_t e;
    e = sb_a.pop_front();
    check({tag, " hex"},  a_if.HEX, e.hex[20:0]);
    check({tag, " ovf"},  a_if.overflow, e.ovf);
    check({tag, " busy"}, a_if.busy, 1'b0);
    prev_a = e.hex[20:0];
  endtask

  task automatic conv_a(input int unsigned v, input string tag);
    int cyc;
    @(negedge clk);
    a_if.start = 1'b1;
    a_if.num   = 10'(v);
    sb_a.push_back(model(v, 3));
    @(negedge clk);
    a_if.start = 1'b0;
    a_if.num   = ~a_if.num;
    check({tag, " busy_on"}, a_if.busy, 1'b1);
    check({tag, " hold"},    a_if.HEX, prev_a);
    wait_done_a(cyc);
    check({tag, " latency"}, cyc, 11);
    result_a(tag);
    @(negedge clk);
    check({tag, " done_pulse"}, a_if.done, 1'b0);
  endtask

  task automatic conv_b(input int unsigned v);
    int   cyc;
    exp_t e;
    @(negedge clk);
    b_if.start = 1'b1;
    b_if.num   = 7'(v);
    sb_b.push_back(model(v, 2));
    @(negedge clk);
    b_if.start = 1'b0;
    check("b hold", b_if.HEX, prev_b);
    cyc = 0;
    while (b_if.done !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check("b latency", cyc, 8);
    e = sb_b.pop_front();
    check("b hex", b_if.HEX, e.hex[13:0]);
    check("b ovf", b_if.overflow, e.ovf);
    prev_b = e.hex[13:0];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    int   done_seen;
    exp_t e;

    reset_n    = 1'b0;
    a_if.start = 1'b0;
    a_if.num   = '0;
    b_if.start = 1'b0;
    b_if.num   = '0;
    prev_a     = {3{7'b1111111}};
    prev_b     = {2{7'b1111111}};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst hex",  a_if.HEX, 21'h1FFFFF);
    check("rst busy", a_if.busy, 1'b0);
    check("rst done", a_if.done, 1'b0);
    check("rst ovf",  a_if.overflow, 1'b0);
    reset_n = 1'b1;

    // Idle: 20 cycles without start change nothing.
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_if.done === 1'b1 || a_if.busy === 1'b1) done_seen++;
    end
    check("idle activity", done_seen, 0);
    check("idle hex", a_if.HEX, 21'h1FFFFF);

    // Basic conversions and full-scale/overflow.
    conv_a(0,    "n0");
    conv_a(7,    "n7");
    conv_a(105,  "n105");
    conv_a(999,  "n999");
    conv_a(1023, "n1023");

    // Handshake: a start while busy is ignored.
    @(negedge clk);
    a_if.start = 1'b1;
    a_if.num   = 10'd42;
    sb_a.push_back(model(42, 3));
    @(negedge clk);
    a_if.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a_if.start = 1'b1;
    a_if.num   = 10'd7;
    @(negedge clk);
    a_if.start = 1'b0;
    wait_done_a(cyc);
    check("hs42 latency", cyc, 8);
    result_a("hs42");

    // Back-to-back: start in the done cycle.
    a_if.start = 1'b1;
    a_if.num   = 10'd7;
    sb_a.push_back(model(7, 3));
    @(negedge clk);
    a_if.start = 1'b0;
    check("hs single done", a_if.done, 1'b0);
    check("hs7 busy_on", a_if.busy, 1'b1);
    wait_done_a(cyc);
    check("hs7 latency", cyc, 11);
    result_a("hs7");

    // Reset mid-conversion.
    @(negedge clk);
    a_if.start = 1'b1;
    a_if.num   = 10'd512;
    @(negedge clk);
    a_if.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid rst hex",  a_if.HEX, 21'h1FFFFF);
    check("mid rst busy", a_if.busy, 1'b0);
    check("mid rst ovf",  a_if.overflow, 1'b0);
    prev_a = {3{7'b1111111}};
    prev_b = {2{7'b1111111}};
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (a_if.done === 1'b1) done_seen++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (a_if.done === 1'b1) done_seen++;
    end
    check("mid rst no done", done_seen, 0);
    conv_a(512, "n512");

    // 7-bit / 2-digit sweep over the full input range.
    for (int v = 0; v < 128; v++) conv_b(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
